// File: rtl/code_loader_if.sv
// ---------------------------------------------------------------------------
// code_loader_if
//   Byte-stream handshake between an upstream byte source and the code
//   loader. A byte moves on a clock edge where rx_valid and rx_ready are
//   both high; the source holds rx_valid/rx_data until that happens.
//
//   Signals:
//     rx_valid  byte available on rx_data (source -> loader)
//     rx_data   8-bit incoming byte       (source -> loader)
//     rx_ready  loader can take a byte    (loader -> source)
//
//   Modports:
//     master  the byte source
//     slave   the loader
// ---------------------------------------------------------------------------
interface code_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_valid, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/code_loader.sv
// ---------------------------------------------------------------------------
// code_loader
//   Boot-time program loader placed in front of the processor's code RAM.
//   It receives a framed byte stream, packs every three payload bytes into
//   one 18-bit instruction word, writes each word into the code RAM, and
//   holds the processor in reset until a complete image with a matching
//   checksum has been written.
//
//   Frame: 0xA5, LEN_LO, LEN_HI, N x (B0, B1, B2), CHK
//     word = {B2[1:0], B1, B0}, B2[7:2] must be zero,
//     CHK  = XOR of LEN_LO, LEN_HI and every payload byte.
//
//   Ports:
//     clock       system clock
//     reset       synchronous, active-high
//     rx          byte-stream handshake (code_loader_if.slave)
//     code_we     code RAM write strobe, one cycle per word
//     code_waddr  code RAM word address
//     code_wdata  code RAM write data
//     cpu_reset   processor reset, active-high, low only once loaded
//     load_done   image loaded and verified
//     load_error  last frame rejected
//
//   Optional feature macro: CODE_LOADER_RELOAD_EN
//     defined   : a 0xA5 accepted after a successful load starts a new load
//                 at address 0 and puts the processor back into reset.
//     undefined : a successful load is terminal until reset.
// ---------------------------------------------------------------------------
module code_loader #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  code_loader_if.slave         rx,
  output logic                 code_we,
  output logic [ADDR_SIZE-1:0] code_waddr,
  output logic [WORD_SIZE-1:0] code_wdata,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_error
);

  localparam logic [7:0]  SyncByte = 8'hA5;
  // One bit wider than the length field so MEM_SIZE = 65536 still compares correctly.
  localparam logic [16:0] MemLimit = 17'(MEM_SIZE);

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    B0,
    B1,
    B2,
    WR,
    CHK,
    DONE,
    ERROR
  } state_t;

  state_t      state_q,    state_d;
  logic [15:0] frameLen_q, frameLen_d;
  logic [15:0] wordCnt_q,  wordCnt_d;
  logic [7:0]  checksum_q, checksum_d;
  logic [17:0] wordBuf_q,  wordBuf_d;

  logic        rxReady;
  logic        rxAccept;
  logic        rxSync;
  logic [15:0] lenFull;
  logic [15:0] cntInc;

  assign rxReady  = (state_q != WR);
  assign rxAccept = rx.rx_valid && rxReady;
  assign rxSync   = (rx.rx_data == SyncByte);
  assign lenFull  = {rx.rx_data, frameLen_q[7:0]};
  assign cntInc   = wordCnt_q + 16'd1;

  // State register and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      frameLen_q <= '0;
      wordCnt_q  <= '0;
      checksum_q <= '0;
      wordBuf_q  <= '0;
    end else begin
      state_q    <= state_d;
      frameLen_q <= frameLen_d;
      wordCnt_q  <= wordCnt_d;
      checksum_q <= checksum_d;
      wordBuf_q  <= wordBuf_d;
    end
  end

  // Frame parser: next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    frameLen_d = frameLen_q;
    wordCnt_d  = wordCnt_q;
    checksum_d = checksum_q;
    wordBuf_d  = wordBuf_q;

    case (state_q)
      // ERROR behaves exactly like IDLE except that load_error stays up
      // until the next sync byte arrives.
      IDLE, ERROR: begin
        if (rxAccept && rxSync) begin
          checksum_d = '0;
          wordCnt_d  = '0;
          state_d    = LEN_LO;
        end
      end

      LEN_LO: begin
        if (rxAccept) begin
          frameLen_d[7:0] = rx.rx_data;
          checksum_d      = checksum_q ^ rx.rx_data;
          state_d         = LEN_HI;
        end
      end

      LEN_HI: begin
        if (rxAccept) begin
          frameLen_d[15:8] = rx.rx_data;
          checksum_d       = checksum_q ^ rx.rx_data;
          if ({1'b0, lenFull} > MemLimit) begin
            state_d = ERROR;
          end else if (lenFull == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = B0;
          end
        end
      end

      B0: begin
        if (rxAccept) begin
          wordBuf_d[7:0] = rx.rx_data;
          checksum_d     = checksum_q ^ rx.rx_data;
          state_d        = B1;
        end
      end

      B1: begin
        if (rxAccept) begin
          wordBuf_d[15:8] = rx.rx_data;
          checksum_d      = checksum_q ^ rx.rx_data;
          state_d         = B2;
        end
      end

      // Only the two low bits of B2 carry data; anything above them marks a
      // corrupt stream and the word is never written.
      B2: begin
        if (rxAccept) begin
          wordBuf_d[17:16] = rx.rx_data[1:0];
          checksum_d       = checksum_q ^ rx.rx_data;
          state_d          = (rx.rx_data[7:2] != 6'd0) ? ERROR : WR;
        end
      end

      // Single write cycle; input is stalled so no byte can be taken here.
      WR: begin
        wordCnt_d = cntInc;
        state_d   = (cntInc == frameLen_q) ? CHK : B0;
      end

      CHK: begin
        if (rxAccept) begin
          state_d = (rx.rx_data == checksum_q) ? DONE : ERROR;
        end
      end

      DONE: begin
`ifdef CODE_LOADER_RELOAD_EN
        if (rxAccept && rxSync) begin
          checksum_d = '0;
          wordCnt_d  = '0;
          state_d    = LEN_LO;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // All outputs decode directly from registered state, so cpu_reset and
  // load_done change on the very edge that enters or leaves DONE.
  assign rx.rx_ready = rxReady;
  assign code_we     = (state_q == WR);
  assign code_waddr  = ADDR_SIZE'(wordCnt_q);
  assign code_wdata  = WORD_SIZE'(wordBuf_q);
  assign cpu_reset   = (state_q != DONE);
  assign load_done   = (state_q == DONE);
  assign load_error  = (state_q == ERROR);

endmodule

// File: tb/tb_code_loader.sv
// ---------------------------------------------------------------------------
// tb_code_loader
//   Self-checking bench for code_loader. Frames are generated from a word
//   list plus optional faults; the expected RAM writes and final status are
//   derived from the frame rules and pushed into a scoreboard queue that a
//   free-running monitor drains whenever the loader writes a word.
// ---------------------------------------------------------------------------
module tb_code_loader;

  localparam int ADDR_SIZE = 18;
  localparam int WORD_SIZE = 18;
  localparam int MEM_SIZE  = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 code_we;
  logic [ADDR_SIZE-1:0] code_waddr;
  logic [WORD_SIZE-1:0] code_wdata;
  logic                 cpu_reset;
  logic                 load_done;
  logic                 load_error;

  int  checks   = 0;
  int  failures = 0;
  bit  monEn    = 1'b0;
  wr_t expQ[$];
  wr_t expWr;
  logic [17:0] ram [0:MEM_SIZE-1];

  code_loader_if rx ();

  code_loader #(
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .code_we    (code_we),
    .code_waddr (code_waddr),
    .code_wdata (code_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Global time limit so a stuck design can never hang the run.
  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: drains the scoreboard on every write strobe and keeps an image
  // of what the loader has written.
  always @(negedge clock) begin
    if (monEn) begin
      checkOutput("rx_ready_only_outside_wr", 32'(rx.rx_ready), 32'(!code_we));
      if (code_we === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   code_waddr, code_wdata);
        end else begin
          expWr = expQ.pop_front();
          checkOutput("write_addr", 32'(code_waddr), expWr.addr);
          checkOutput("write_data", 32'(code_wdata), expWr.data);
        end
        ram[code_waddr[9:0]] = code_wdata;
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"},   32'(rx.rx_ready), 32'd1);
    checkOutput({tag, "_code_we"},    32'(code_we),     32'd0);
    checkOutput({tag, "_code_waddr"}, 32'(code_waddr),  32'd0);
    checkOutput({tag, "_code_wdata"}, 32'(code_wdata),  32'd0);
    checkOutput({tag, "_cpu_reset"},  32'(cpu_reset),   32'd1);
    checkOutput({tag, "_load_done"},  32'(load_done),   32'd0);
    checkOutput({tag, "_load_error"}, 32'(load_error),  32'd0);
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic applyReset();
    rx.rx_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Offers one byte and holds it until the loader takes it. Entered and left
  // at a falling edge, so rx_ready seen here is the value at the next rising edge.
  task automatic sendByte(input logic [7:0] b);
    bit acc;
    int waited;
    rx.rx_valid = 1'b1;
    rx.rx_data  = b;
    waited      = 0;
    do begin
      acc = rx.rx_ready;
      @(negedge clock);
      waited++;
    end while (!acc && waited < 50);
    checkOutput("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] f[$], input int maxGap);
    int gap;
    foreach (f[i]) begin
      sendByte(f[i]);
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      if (gap > 0) begin
        rx.rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
    end
    rx.rx_valid = 1'b0;
  endtask

  // Reference model plus driver for one frame. badIdx < 0 means all B2 bytes
  // are well formed; chkFlip != 0 corrupts the checksum byte.
  task automatic runFrame(input string tag, input logic [15:0] n, input logic [17:0] words[$],
                          input logic [7:0] chkFlip, input int badIdx, input logic [7:0] badMask,
                          input int maxGap);
    logic [7:0] f[$];
    logic [7:0] x;
    logic [7:0] b2;
    bit         expOk;
    int         nWritten;

    f        = {8'hA5, n[7:0], n[15:8]};
    x        = n[7:0] ^ n[15:8];
    expOk    = 1'b1;
    nWritten = 0;

    if (int'(n) > MEM_SIZE) begin
      expOk = 1'b0;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        b2 = {6'd0, words[i][17:16]};
        if (i == badIdx) b2 = b2 | badMask;
        f.push_back(words[i][7:0]);
        f.push_back(words[i][15:8]);
        f.push_back(b2);
        x = x ^ words[i][7:0] ^ words[i][15:8] ^ b2;
        if (b2[7:2] != 6'd0) begin
          expOk = 1'b0;
          break;
        end
        expQ.push_back('{32'(i), 32'(words[i])});
        nWritten++;
      end
      if (expOk) begin
        f.push_back(x ^ chkFlip);
        if (chkFlip != 8'd0) expOk = 1'b0;
      end
    end

    applyStimulus(f, maxGap);

    checkOutput({tag, "_load_done"},  32'(load_done),  32'(expOk));
    checkOutput({tag, "_load_error"}, 32'(load_error), 32'(!expOk));
    checkOutput({tag, "_cpu_reset"},  32'(cpu_reset),  32'(!expOk));
    checkOutput({tag, "_writes_left"}, 32'(expQ.size()), 32'd0);
    if (expOk) begin
      for (int i = 0; i < int'(n); i++) begin
        checkOutput({tag, "_ram_image"}, 32'(ram[i]), 32'(words[i]));
      end
    end
    expQ.delete();
  endtask

  initial begin
    logic [17:0] words[$];
    logic [15:0] n;
    int          kind;
    int          badIdx;
    logic [7:0]  mask;
    logic [7:0]  chkFlip;
    logic [7:0]  junk;

    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    reset       = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkResetValues("reset");
    reset = 1'b0;
    monEn = 1'b1;

    // Two-word image 0x31234, 0x00001; the XOR of its bytes is 0x26.
    words = {18'h31234, 18'h00001};
    runFrame("two_words", 16'd2, words, 8'h00, -1, 8'h00, 0);

`ifdef CODE_LOADER_RELOAD_EN
    // A sync byte after DONE puts the processor back into reset at once.
    sendByte(8'hA5);
    checkOutput("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("reload_load_done", 32'(load_done), 32'd0);
    expQ.push_back('{32'd0, 32'h2AAAA});
    applyStimulus({8'h01, 8'h00, 8'hAA, 8'hAA, 8'h02, 8'h03}, 0);
    checkOutput("reload_done",        32'(load_done),    32'd1);
    checkOutput("reload_writes_left", 32'(expQ.size()), 32'd0);
    checkOutput("reload_ram0",        32'(ram[0]),      32'h2AAAA);
`else
    // DONE is terminal: further bytes, even a sync byte, are swallowed.
    applyStimulus({8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h01}, 0);
    checkOutput("terminal_load_done", 32'(load_done), 32'd1);
    checkOutput("terminal_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("terminal_rx_ready",  32'(rx.rx_ready), 32'd1);
`endif

    // Empty image: done after exactly four accepted bytes.
    applyReset();
    applyStimulus({8'hA5, 8'h00, 8'h00}, 0);
    checkOutput("empty_not_done_yet", 32'(load_done), 32'd0);
    sendByte(8'h00);
    rx.rx_valid = 1'b0;
    checkOutput("empty_done",      32'(load_done), 32'd1);
    checkOutput("empty_cpu_reset", 32'(cpu_reset), 32'd0);

    // Checksum byte 0x25 instead of 0x26, then the correct frame recovers.
    applyReset();
    runFrame("bad_chk", 16'd2, words, 8'h03, -1, 8'h00, 0);
    runFrame("after_bad_chk", 16'd2, words, 8'h00, -1, 8'h00, 1);

    // B2 = 0x04 on the first word: error with no write.
    applyReset();
    words = {18'h00000, 18'h00001};
    runFrame("bad_b2", 16'd2, words, 8'h00, 0, 8'h04, 0);

    // Length one past the RAM depth is rejected right after LEN_HI.
    applyReset();
    runFrame("len_too_big", 16'h0401, words, 8'h00, -1, 8'h00, 0);

    // Length exactly equal to the RAM depth is accepted, back-to-back bytes.
    applyReset();
    words.delete();
    for (int i = 0; i < MEM_SIZE; i++) words.push_back(18'($urandom));
    runFrame("full_ram", 16'(MEM_SIZE), words, 8'h00, -1, 8'h00, 0);

    // Reset asserted during the write cycle.
    applyReset();
    expQ.push_back('{32'd0, 32'h1BEEF});
    applyStimulus({8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'h01}, 0);
    checkOutput("mid_wr_code_we", 32'(code_we), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkResetValues("mid_wr_reset");
    reset = 1'b0;
    checkOutput("mid_wr_writes_left", 32'(expQ.size()), 32'd0);
    expQ.delete();

    // Randomized frames with optional junk, faults and gaps.
    applyReset();
    for (int t = 0; t < 30; t++) begin
      if (load_done) applyReset();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        sendByte(junk);
      end
      rx.rx_valid = 1'b0;
      kind    = int'($urandom_range(0, 5));
      n       = 16'($urandom_range(1, 8));
      chkFlip = 8'h00;
      badIdx  = -1;
      mask    = 8'h00;
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back(18'($urandom));
      if (kind == 3) chkFlip = 8'($urandom_range(1, 255));
      if (kind == 4) begin
        badIdx = int'($urandom_range(0, int'(n) - 1));
        mask   = 8'(8'h04 << $urandom_range(0, 5));
      end
      if (kind == 5) n = 16'($urandom_range(MEM_SIZE + 1, 65535));
      runFrame("random", n, words, chkFlip, badIdx, mask, int'($urandom_range(0, 1)) * 2);
    end

    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
